// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: FSM states, key-length codes, round counts.
// Nr lookup folds the reserved key_len code onto AES-128.
package aes_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MIXA  = 3'd1,
      S_MIXB  = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] KEY_128 = 2'b00;
   localparam logic [1:0] KEY_192 = 2'b01;
   localparam logic [1:0] KEY_256 = 2'b10;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   function automatic logic [3:0] nr_of(input logic [1:0] key_len);
      case (key_len)
         KEY_192: nr_of = NR_192;
         KEY_256: nr_of = NR_256;
         default: nr_of = NR_128;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block handshake between the AES round controller and its producer/consumer.
// master = producer/consumer side, slave = controller side.
interface aes_round_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] key_len;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_valid, key_len, out_ready,
      input  in_ready, out_valid
   );

   modport slave (
      input  in_valid, key_len, out_ready,
      output in_ready, out_valid
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequences the AES round datapath: load, Nr-1 two-cycle mix rounds, final round, hold result.
// Latency 2*Nr cycles accept-to-out_valid; DONE holds until out_ready, in_ready only in IDLE.
module aes_round_ctrl
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   aes_round_ctrl_if.slave  bus,
   output logic             dp_load,
   output logic             dp_state_en,
   output logic             dp_mix_en,
   output logic             dp_bypass_mix,
   output logic [3:0]       round_idx,
   output logic             busy
);

   state_t     state, state_nxt;
   logic [3:0] round, round_nxt;
   logic [3:0] nr, nr_nxt;
   logic       in_rdy, out_vld;

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign busy          = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         round <= 4'd0;
         nr    <= NR_128;
      end else begin
         state <= state_nxt;
         round <= round_nxt;
         nr    <= nr_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      round_nxt     = round;
      nr_nxt        = nr;
      in_rdy        = 1'b0;
      out_vld       = 1'b0;
      dp_load       = 1'b0;
      dp_state_en   = 1'b0;
      dp_mix_en     = 1'b0;
      dp_bypass_mix = 1'b0;
      round_idx     = 4'd0;

      case (state)
         S_IDLE: begin
            in_rdy = 1'b1;
            if (bus.in_valid) begin
               dp_load     = 1'b1;
               dp_state_en = 1'b1;
               nr_nxt      = nr_of(bus.key_len);
               round_nxt   = 4'd1;
               state_nxt   = S_MIXA;
            end
         end
         // Mix-columns needs a pipeline cycle before the state register can capture.
         S_MIXA: begin
            dp_mix_en = 1'b1;
            round_idx = round;
            state_nxt = S_MIXB;
         end
         S_MIXB: begin
            dp_state_en = 1'b1;
            round_idx   = round;
            if (round < NR_256)
               round_nxt = round + 4'd1;
            if (round == nr - 4'd1)
               state_nxt = S_FINAL;
            else
               state_nxt = S_MIXA;
         end
         S_FINAL: begin
            dp_state_en   = 1'b1;
            dp_bypass_mix = 1'b1;
            round_idx     = nr;
            state_nxt     = S_DONE;
         end
         S_DONE: begin
            out_vld = 1'b1;
            if (bus.out_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
